// File: rtl/e_md_issue_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide issue controller.
// Holds the md op-code encoding, the tracking FSM state encoding and the
// default result latencies. The multdiv unit uses the same latencies.
package e_md_issue_ctrl_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MULT_LAT = 6;
  localparam int unsigned DIV_LAT  = 11;

  // md op codes; MD_NONE marks a non-md instruction
  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  // Tracking FSM: which long-latency op (if any) is in flight
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // True for ops that launch a long-latency multdiv computation
  function automatic logic md_op_starts(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_md_issue_ctrl_md_op_class.sv
// Combinational classifier for E-stage md op codes.
// Ports:
//   op      in  4  md op code
//   is_mul  out 1  mult/multu
//   is_div  out 1  div/divu
//   is_mt   out 1  mthi/mtlo
//   is_mf   out 1  mfhi/mflo
module e_md_issue_ctrl_md_op_class
  import e_md_issue_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output logic       is_mul,
  output logic       is_div,
  output logic       is_mt,
  output logic       is_mf
);

  // One-hot-or-zero class decode; unknown codes decode to no class
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    is_mt  = 1'b0;
    is_mf  = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: is_mul = 1'b1;
      MD_DIV,  MD_DIVU:  is_div = 1'b1;
      MD_MTHI, MD_MTLO:  is_mt  = 1'b1;
      MD_MFHI, MD_MFLO:  is_mf  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/e_md_issue_ctrl.sv
// E-stage initiator for the multiply/divide unit.
// Issues start pulses and operands for md instructions, tracks the in-flight
// mult/div with a local latency counter, stalls dependent md instructions
// until HI/LO are final, muxes mfhi/mflo read data back to the E stage, and
// flags any disagreement between multdiv busy and the local tracking.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   e_valid, e_md_op      E-stage instruction valid and md op code
//   e_rs, e_rt            forwarded operands
//   md_busy, md_hi, md_lo status and results from multdiv
//   md_start, md_c        start pulse and op code to multdiv
//   md_data1, md_data2    operands to multdiv (0 when not issuing)
//   stall                 freeze F/D/E, bubble into M
//   md_rdata, md_rvalid   mfhi/mflo read data and its valid
//   mismatch              sticky busy-tracking disagreement flag
module e_md_issue_ctrl
  import e_md_issue_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT_P = MULT_LAT,
  parameter int unsigned DIV_LAT_P  = DIV_LAT,
  parameter int unsigned CNT_W_P    = CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_start,
  output logic [3:0]  md_c,
  output logic [31:0] md_data1,
  output logic [31:0] md_data2,
  output logic        stall,
  output logic [31:0] md_rdata,
  output logic        md_rvalid,
  output logic        mismatch
);

  md_state_e          state;
  logic [CNT_W_P-1:0] cnt;

  logic is_mul;
  logic is_div;
  logic is_mt;
  logic is_mf;
  logic md_use;
  logic cnt_nz;
  logic issue;

  e_md_issue_ctrl_md_op_class u_md_op_class (
    .op     (e_md_op),
    .is_mul (is_mul),
    .is_div (is_div),
    .is_mt  (is_mt),
    .is_mf  (is_mf)
  );

  // Gating md_use with reset forces every output to its idle value while
  // reset is held, even though the outputs are combinational.
  assign cnt_nz = (cnt != '0);
  assign md_use = reset && e_valid && (e_md_op != MD_NONE);
  assign stall  = md_use && (cnt_nz || md_busy);
  assign issue  = md_use && !stall;

  // Issue-side outputs; mfhi/mflo never reach multdiv (md_c stays MD_NONE)
  always_comb begin
    md_start  = 1'b0;
    md_c      = MD_NONE;
    md_data1  = '0;
    md_data2  = '0;
    md_rvalid = 1'b0;
    md_rdata  = '0;
    if (issue) begin
      md_data1  = e_rs;
      md_data2  = e_rt;
      md_start  = md_op_starts(e_md_op);
      md_rvalid = is_mf;
      if (is_mul || is_div || is_mt) begin
        md_c = e_md_op;
      end
    end
    if (md_use && is_mf) begin
      md_rdata = (e_md_op == MD_MFHI) ? md_hi : md_lo;
    end
  end

  // Tracking FSM, latency counter and sticky busy checker.
  // The checker skips the start cycle because multdiv masks busy with start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mismatch <= 1'b0;
    end else begin
      if (!md_start && (md_busy != cnt_nz)) begin
        mismatch <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (issue && is_mul) begin
            state <= ST_MULT;
            cnt   <= CNT_W_P'(MULT_LAT_P);
          end else if (issue && is_div) begin
            state <= ST_DIV;
            cnt   <= CNT_W_P'(DIV_LAT_P);
          end
        end
        ST_MULT, ST_DIV: begin
          // The op cannot be cancelled, so counting ignores e_valid
          if (cnt <= CNT_W_P'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W_P'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_md_issue_ctrl.sv
// Directed self-checking bench for e_md_issue_ctrl with a small multdiv model.
module tb_e_md_issue_ctrl;
  import e_md_issue_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_start;
  logic [3:0]  md_c;
  logic [31:0] md_data1;
  logic [31:0] md_data2;
  logic        stall;
  logic [31:0] md_rdata;
  logic        md_rvalid;
  logic        mismatch;

  int checks;
  int errors;

  e_md_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_md_op   (e_md_op),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .md_busy   (md_busy),
    .md_hi     (md_hi),
    .md_lo     (md_lo),
    .md_start  (md_start),
    .md_c      (md_c),
    .md_data1  (md_data1),
    .md_data2  (md_data2),
    .stall     (stall),
    .md_rdata  (md_rdata),
    .md_rvalid (md_rvalid),
    .mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multdiv: busy masked in the start cycle, HI/LO final after LAT edges
  logic [3:0]  m_cnt;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        force_en;
  logic        force_val;

  function automatic logic [63:0] md_result(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return {32'd0, a} * {32'd0, b};
      MD_DIV:   return (b == 0) ? 64'd0 : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      MD_DIVU:  return (b == 0) ? 64'd0 : {a % b, a / b};
      default:  return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_cnt <= 4'd0;
      md_hi <= 32'd0;
      md_lo <= 32'd0;
    end else if (md_start) begin
      m_cnt <= (md_c == MD_MULT || md_c == MD_MULTU) ? 4'd6 : 4'd11;
      {p_hi, p_lo} <= md_result(md_c, md_data1, md_data2);
    end else if (m_cnt != 4'd0) begin
      if (m_cnt == 4'd1) begin
        md_hi <= p_hi;
        md_lo <= p_lo;
      end
      m_cnt <= m_cnt - 4'd1;
    end else if (md_c == MD_MTHI) begin
      md_hi <= md_data1;
    end else if (md_c == MD_MTLO) begin
      md_lo <= md_data1;
    end
  end

  assign md_busy = force_en ? force_val : (m_cnt != 4'd0);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [3:0] op, input logic [31:0] rs,
                           input logic [31:0] rt);
    e_valid = v;
    e_md_op = op;
    e_rs    = rs;
    e_rt    = rt;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    set_instr(1'b1, MD_MULT, 32'd1, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick;
      #2;
      checks++;
      if ({md_start, stall, md_c, mismatch} !== {1'b0, 1'b0, 4'(MD_NONE), 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc%0d start/stall/c/mm got %b %b %h %b want 0 0 0 0",
                 i, md_start, stall, md_c, mismatch);
      end
    end
    tick;
    reset = 1'b1;
    set_instr(1'b0, MD_NONE, 32'd0, 32'd0);
    #2;
    checks++;
    if ({md_start, stall, md_c, mismatch, md_rvalid} !== {1'b0, 1'b0, 4'(MD_NONE), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release start/stall/c/mm/rv got %b %b %h %b %b want 0 0 0 0 0",
               md_start, stall, md_c, mismatch, md_rvalid);
    end
    tick;
  endtask

  task automatic test_mult_mflo;
    set_instr(1'b1, MD_MULT, 32'd3, 32'hFFFF_FFFE);
    #2;
    checks++;
    if ({md_start, stall, md_c, md_data1, md_data2} !==
        {1'b1, 1'b0, 4'(MD_MULT), 32'd3, 32'hFFFF_FFFE}) begin
      errors++;
      $display("FAIL mult_issue start/stall/c/d1/d2 got %b %b %h %h %h want 1 0 1 3 fffffffe",
               md_start, stall, md_c, md_data1, md_data2);
    end
    tick;
    set_instr(1'b1, MD_MFLO, 32'd0, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      #2;
      checks++;
      if ({stall, md_start, md_rvalid} !== 3'b100) begin
        errors++;
        $display("FAIL mflo_stall T+%0d stall/start/rv got %b%b%b want 100",
                 i, stall, md_start, md_rvalid);
      end
      tick;
    end
    #2;
    checks++;
    if ({stall, md_rvalid, md_rdata, md_c, md_start} !==
        {1'b0, 1'b1, 32'hFFFF_FFFA, 4'(MD_NONE), 1'b0}) begin
      errors++;
      $display("FAIL mflo_read stall/rv/rdata/c/start got %b %b %h %h %b want 0 1 fffffffa 0 0",
               stall, md_rvalid, md_rdata, md_c, md_start);
    end
    tick;
    set_instr(1'b0, MD_NONE, 32'd0, 32'd0);
  endtask

  task automatic test_divu_mfhi;
    int starts;
    starts = 0;
    set_instr(1'b1, MD_DIVU, 32'd7, 32'd2);
    #2;
    starts += int'(md_start);
    checks++;
    if ({md_start, md_c} !== {1'b1, 4'(MD_DIVU)}) begin
      errors++;
      $display("FAIL divu_issue start/c got %b %h want 1 4", md_start, md_c);
    end
    tick;
    set_instr(1'b1, MD_MFHI, 32'd0, 32'd0);
    for (int i = 1; i <= 11; i++) begin
      #2;
      starts += int'(md_start);
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL mfhi_stall T+%0d stall got %b want 1", i, stall);
      end
      tick;
    end
    #2;
    starts += int'(md_start);
    checks++;
    if ({stall, md_rvalid, md_rdata} !== {1'b0, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL mfhi_read stall/rv/rdata got %b %b %h want 0 1 00000001",
               stall, md_rvalid, md_rdata);
    end
    checks++;
    if (starts != 1) begin
      errors++;
      $display("FAIL divu_start_count got %0d want 1", starts);
    end
    tick;
    set_instr(1'b0, MD_NONE, 32'd0, 32'd0);
  endtask

  task automatic test_non_md_overlap;
    set_instr(1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd2);
    #2;
    checks++;
    if (md_start !== 1'b1) begin
      errors++;
      $display("FAIL ovl_mult_issue start got %b want 1", md_start);
    end
    tick;
    set_instr(1'b1, MD_NONE, 32'h1234, 32'h5678);
    for (int i = 1; i <= 3; i++) begin
      #2;
      checks++;
      if ({stall, md_start, md_c, md_data1} !== {1'b0, 1'b0, 4'(MD_NONE), 32'd0}) begin
        errors++;
        $display("FAIL ovl_non_md T+%0d stall/start/c/d1 got %b %b %h %h want 0 0 0 0",
                 i, stall, md_start, md_c, md_data1);
      end
      tick;
    end
    set_instr(1'b1, MD_MFHI, 32'd0, 32'd0);
    for (int i = 4; i <= 6; i++) begin
      #2;
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL ovl_mfhi_stall T+%0d stall got %b want 1", i, stall);
      end
      tick;
    end
    #2;
    checks++;
    if ({stall, md_rvalid, md_rdata} !== {1'b0, 1'b1, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL ovl_mfhi_read stall/rv/rdata got %b %b %h want 0 1 ffffffff",
               stall, md_rvalid, md_rdata);
    end
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL ovl_no_mismatch got %b want 0", mismatch);
    end
    tick;
    set_instr(1'b0, MD_NONE, 32'd0, 32'd0);
  endtask

  task automatic test_reset_mid_div;
    set_instr(1'b1, MD_DIV, 32'd100, 32'd7);
    #2;
    checks++;
    if ({md_start, md_c} !== {1'b1, 4'(MD_DIV)}) begin
      errors++;
      $display("FAIL rdiv_issue start/c got %b %h want 1 3", md_start, md_c);
    end
    tick;
    set_instr(1'b0, MD_MTLO, 32'd0, 32'd0);
    for (int i = 1; i <= 2; i++) begin
      #2;
      checks++;
      if ({stall, md_c} !== {1'b0, 4'(MD_NONE)}) begin
        errors++;
        $display("FAIL rdiv_bubble T+%0d stall/c got %b %h want 0 0", i, stall, md_c);
      end
      tick;
    end
    reset = 1'b0;
    set_instr(1'b1, MD_MTLO, 32'h55, 32'd0);
    #2;
    checks++;
    if ({stall, md_start, md_c, md_data1} !== {1'b0, 1'b0, 4'(MD_NONE), 32'd0}) begin
      errors++;
      $display("FAIL rdiv_in_reset stall/start/c/d1 got %b %b %h %h want 0 0 0 0",
               stall, md_start, md_c, md_data1);
    end
    tick;
    reset = 1'b1;
    #2;
    checks++;
    if ({stall, md_start, md_c, md_data1} !== {1'b0, 1'b0, 4'(MD_MTLO), 32'h55}) begin
      errors++;
      $display("FAIL rdiv_mtlo stall/start/c/d1 got %b %b %h %h want 0 0 6 55",
               stall, md_start, md_c, md_data1);
    end
    tick;
    set_instr(1'b1, MD_MFLO, 32'd0, 32'd0);
    #2;
    checks++;
    if ({stall, md_rvalid, md_rdata, mismatch} !== {1'b0, 1'b1, 32'h55, 1'b0}) begin
      errors++;
      $display("FAIL rdiv_mflo stall/rv/rdata/mm got %b %b %h %b want 0 1 55 0",
               stall, md_rvalid, md_rdata, mismatch);
    end
    tick;
    set_instr(1'b0, MD_NONE, 32'd0, 32'd0);
  endtask

  task automatic test_mismatch;
    set_instr(1'b1, MD_MULT, 32'd2, 32'd3);
    tick;
    set_instr(1'b0, MD_NONE, 32'd0, 32'd0);
    #2;
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL mm_T1 got %b want 0", mismatch);
    end
    tick;
    force_en  = 1'b1;
    force_val = 1'b0;
    #2;
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL mm_T2 got %b want 0", mismatch);
    end
    tick;
    force_en = 1'b0;
    for (int i = 3; i <= 12; i++) begin
      #2;
      checks++;
      if (mismatch !== 1'b1) begin
        errors++;
        $display("FAIL mm_sticky T+%0d got %b want 1", i, mismatch);
      end
      tick;
    end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    #2;
    checks++;
    if ({mismatch, stall} !== 2'b00) begin
      errors++;
      $display("FAIL mm_cleared mm/stall got %b %b want 0 0", mismatch, stall);
    end
    tick;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    force_en  = 1'b0;
    force_val = 1'b0;
    p_hi      = 32'd0;
    p_lo      = 32'd0;
    reset     = 1'b0;
    set_instr(1'b0, MD_NONE, 32'd0, 32'd0);
    test_reset;
    test_mult_mflo;
    test_divu_mfhi;
    test_non_md_overlap;
    test_reset_mid_div;
    test_mismatch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
